// File: rtl/writeback_unit.sv
// writeback_unit: owns the integer register-file write port.
// It merges a single-cycle ALU result stream with buffered LSU results held in
// a small FIFO. x0 is never written, and there is at most one write per cycle.
// If an LSU result loses arbitration to the ALU for STARVE_LIMIT cycles in a
// row, the ALU is stalled for one cycle so the buffered result can drain.
// Optional macro WB_BYPASS_EN adds read-port bypass outputs. These cover the
// cycle in which the register file has not yet absorbed the registered write.
module writeback_unit #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [31:0]             alu_wd,
  output logic                    alu_stall,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [4:0]              lsu_rd,
  input  logic [31:0]             lsu_wd,
  output logic [4:0]              rd,
  output logic [31:0]             wd,
  output logic                    reg_write,
`ifdef WB_BYPASS_EN
  input  logic [4:0]              byp_rs1,
  input  logic [4:0]              byp_rs2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic [31:0]             byp_data,
`endif
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 37;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Saturating increment of the starvation counter
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;
  logic          r_we_p1;
  logic [4:0]    r_rd_p1;
  logic [31:0]   r_wd_p1;

  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_alu_slot;
  logic          w_alu_win;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic [SW-1:0] w_starve_nxt;

  // ---- p0: arbitration on registered FIFO state (no fall-through) ----
  assign w_empty    = (r_count == '0);
  assign w_ready    = (r_count != FULL);
  // An x0 LSU result completes its handshake but is never buffered.
  assign w_push     = lsu_valid && w_ready && (lsu_rd != 5'd0);
  // A non-stalled ALU result owns the slot even when it targets x0.
  // That x0 result is dropped, and the FIFO waits this cycle.
  assign w_alu_slot = alu_valid && !r_stall;
  assign w_alu_win  = w_alu_slot && (alu_rd != 5'd0);
  assign w_pop      = !w_alu_slot && !w_empty;
  assign w_head     = r_mem[r_rptr];

  // Next starvation count. It counts cycles in which a waiting head lost its slot.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty)
      w_starve_nxt = '0;
    else if (w_alu_slot)
      w_starve_nxt = sat_inc(r_starve);
  end

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {lsu_rd, lsu_wd};
  end

  // FIFO pointers, occupancy, starvation counter and the stall flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_nxt;
      // A saturated count implies no pop happened, so the head is still waiting.
      r_stall  <= (w_starve_nxt == LIMIT);
    end
  end

  // ---- p1: registered write port, one cycle after arbitration ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_p1 <= 1'b0;
      r_rd_p1 <= '0;
      r_wd_p1 <= '0;
    end else if (w_alu_win) begin
      r_we_p1 <= 1'b1;
      r_rd_p1 <= alu_rd;
      r_wd_p1 <= alu_wd;
    end else if (w_pop) begin
      r_we_p1 <= 1'b1;
      r_rd_p1 <= w_head[36:32];
      r_wd_p1 <= w_head[31:0];
    end else begin
      r_we_p1 <= 1'b0;
      r_rd_p1 <= '0;
      r_wd_p1 <= '0;
    end
  end

  assign reg_write  = r_we_p1;
  assign rd         = r_rd_p1;
  assign wd         = r_wd_p1;
  assign alu_stall  = r_stall;
  assign lsu_ready  = w_ready;
  assign fifo_count = r_count;

`ifdef WB_BYPASS_EN
  assign byp_hit1 = r_we_p1 && (r_rd_p1 == byp_rs1) && (r_rd_p1 != 5'd0);
  assign byp_hit2 = r_we_p1 && (r_rd_p1 == byp_rs2) && (r_rd_p1 != 5'd0);
  assign byp_data = r_wd_p1;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit. It uses a table of directed vectors,
// hand-written multi-cycle sequences, and a randomized run. All of these are
// compared against a queue-based reference model.
module tb_writeback_unit;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic        reg_write;
  logic [2:0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1;
  logic [4:0]  byp_rs2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data;
`endif

  writeback_unit #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .rd(rd), .wd(wd), .reg_write(reg_write),
`ifdef WB_BYPASS_EN
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data(byp_data),
`endif
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending LSU results plus the starvation state
  logic [36:0] m_q[$];
  int          m_starve = 0;
  bit          m_stall  = 1'b0;
  bit          m_we     = 1'b0;
  logic [4:0]  m_rd     = '0;
  logic [31:0] m_wd     = '0;

  task automatic model_tick();
    bit alu_takes;
    bit do_pop;
    bit had;
    bit can_push;
    logic [36:0] h;
    if (rst) begin
      m_q.delete();
      m_starve = 0; m_stall = 0; m_we = 0; m_rd = '0; m_wd = '0;
      return;
    end
    had       = (m_q.size() > 0);
    can_push  = (m_q.size() < DEPTH);
    alu_takes = alu_valid && !m_stall;
    do_pop    = !alu_takes && had;
    m_we = 0; m_rd = '0; m_wd = '0;
    if (alu_takes && alu_rd != 0) begin
      m_we = 1; m_rd = alu_rd; m_wd = alu_wd;
    end else if (do_pop) begin
      h = m_q.pop_front();
      m_we = 1; m_rd = h[36:32]; m_wd = h[31:0];
    end
    if (do_pop || !had) m_starve = 0;
    else if (alu_takes && m_starve < LIMIT) m_starve++;
    m_stall = (m_starve == LIMIT);
    if (lsu_valid && can_push && lsu_rd != 0) m_q.push_back({lsu_rd, lsu_wd});
  endtask

  // One clock: advance the model, take the edge, compare shortly after it
  task automatic step();
    chk("proto_alu_valid_while_stalled", {63'd0, alu_valid & alu_stall}, 64'd0);
    model_tick();
    @(posedge clk);
    #1;
    chk("reg_write", {63'd0, reg_write}, {63'd0, m_we});
    chk("rd", {59'd0, rd}, {59'd0, m_rd});
    chk("wd", {32'd0, wd}, {32'd0, m_wd});
    chk("fifo_count", {61'd0, fifo_count}, 64'(m_q.size()));
    chk("alu_stall", {63'd0, alu_stall}, {63'd0, m_stall});
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, (m_q.size() < DEPTH)});
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] ewd;
    int          ecnt;
  } vec_t;

  vec_t tbl[7];
  logic [4:0] got_rd[$];
  bit accepted;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        0};
    tbl[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,        1};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11,       1};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h33, 1'b1, 5'd4, 32'h22,       0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        0};
`ifdef WB_BYPASS_EN
    byp_rs1 = '0;
    byp_rs2 = '0;
`endif

    // Reset state
    do_reset();
    chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("rst_fifo_count", {61'd0, fifo_count}, 64'd0);
    chk("rst_alu_stall", {63'd0, alu_stall}, 64'd0);

    // Directed table: ALU-only, then LSU-only with an x0 entry
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].awd, tbl[i].lv, tbl[i].lrd, tbl[i].lwd);
      step();
      chk($sformatf("tbl%0d_we", i), {63'd0, reg_write}, {63'd0, tbl[i].ewe});
      chk($sformatf("tbl%0d_rd", i), {59'd0, rd}, {59'd0, tbl[i].erd});
      chk($sformatf("tbl%0d_wd", i), {32'd0, wd}, {32'd0, tbl[i].ewd});
      chk($sformatf("tbl%0d_cnt", i), {61'd0, fifo_count}, 64'(tbl[i].ecnt));
    end

    // Full FIFO: the ALU stays busy while five LSU results are offered
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 32'(256 + i));
      step();
      chk("full_ready", {63'd0, lsu_ready}, {63'd0, (i < 3)});
      chk("full_count", {61'd0, fifo_count}, 64'((i < 4) ? i + 1 : 4));
    end
    chk("ready_low_during_first_pop", {63'd0, lsu_ready}, 64'd0);
    accepted = 0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      drive(0, 0, 0, 1, 5'd14, 32'd260);
      accepted = lsu_ready;
      step();
      if (reg_write) got_rd.push_back(rd);
    end
    chk("fifth_push_accepted", {63'd0, accepted}, 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (reg_write) got_rd.push_back(rd);
    end
    chk("full_write_total", 64'(got_rd.size()), 64'd5);
    for (int i = 0; i < got_rd.size() && i < 5; i++)
      chk($sformatf("full_order%0d", i), {59'd0, got_rd[i]}, 64'(10 + i));

    // Starvation: one waiting entry and an ALU result every cycle
    do_reset();
    drive(0, 0, 0, 1, 5'd9, 32'h99);
    step();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1, 5'(1 + i), 32'(160 + i), 0, 0, 0);
      step();
      chk("starve_stall", {63'd0, alu_stall}, {63'd0, (i == LIMIT - 1)});
      chk("starve_alu_rd", {59'd0, rd}, 64'(1 + i));
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("starve_pop_we", {63'd0, reg_write}, 64'd1);
    chk("starve_pop_rd", {59'd0, rd}, 64'd9);
    chk("starve_pop_wd", {32'd0, wd}, 64'h99);
    chk("starve_stall_clear", {63'd0, alu_stall}, 64'd0);
    step();
    chk("starve_after_we", {63'd0, reg_write}, 64'd0);

    // Reset with three queued entries discards them
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd2, 32'(i), 1, 5'(6 + i), 32'(48 + i));
      step();
    end
    chk("mid_queued", {61'd0, fifo_count}, 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_count", {61'd0, fifo_count}, 64'd0);
    chk("mid_rst_we", {63'd0, reg_write}, 64'd0);
    chk("mid_rst_stall", {63'd0, alu_stall}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_write", {63'd0, reg_write}, 64'd0);
    end

`ifdef WB_BYPASS_EN
    // Bypass while the registered write is visible
    do_reset();
    byp_rs1 = 5'd7;
    byp_rs2 = 5'd0;
    drive(1, 5'd7, 32'hCAFE, 0, 0, 0);
    step();
    chk("byp_hit1", {63'd0, byp_hit1}, 64'd1);
    chk("byp_hit2", {63'd0, byp_hit2}, 64'd0);
    chk("byp_data", {32'd0, byp_data}, 64'hCAFE);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("byp_hit1_next", {63'd0, byp_hit1}, 64'd0);
    chk("byp_hit2_next", {63'd0, byp_hit2}, 64'd0);
`endif

    // Randomized traffic against the model; ALU pressure varies by phase
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int alu_pct;
      alu_pct = (i < 400) ? 90 : 50;
      rst = ($urandom_range(0, 149) == 0);
      alu_valid = !m_stall && ($urandom_range(1, 100) <= alu_pct);
      alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_wd    = $urandom;
      lsu_valid = ($urandom_range(0, 9) < 6);
      lsu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_wd    = $urandom;
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the integer register file: owns its single write port (rd/wd/reg_write) and merges results from two sources into it.
  - The ALU path is single-cycle and has no backpressure.
  - The load/multi-cycle path (LSU) uses a valid/ready handshake and is buffered in a small FIFO.
- Sits between the execute/memory stages and the register file write port.
- Guarantees at most one write per cycle, never writes x0, and prevents indefinite starvation of buffered LSU results.

Parameters:
- DEPTH, 4, LSU result FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before the ALU is stalled; minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_wd  in  32  ALU result data
- alu_stall  out  1  registered; upstream must hold alu_valid=0 while high
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; equals !full, from the registered count
- lsu_rd  in  5  LSU destination register
- lsu_wd  in  32  LSU result data
- rd  out  5  register file write address
- wd  out  32  register file write data
- reg_write  out  1  register file write enable
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy (debug/verification)

Behaviour:
- Reset (rst=1 at posedge): FIFO pointers and count=0, starve counter=0, alu_stall=0, reg_write=0, rd=0, wd=0. Reset during a pending FIFO entry discards it. Outputs are in reset values the cycle after the reset edge.
- LSU push:
  - Occurs when lsu_valid && lsu_ready at posedge.
  - If lsu_rd==0, the handshake completes but nothing is enqueued (no count change).
  - lsu_ready depends only on the registered count, so it stays low when full even if a pop happens in the same cycle.
- Arbitration, evaluated each cycle:
  - alu_stall=0 and alu_valid=1 and alu_rd!=0: the ALU wins.
  - Otherwise, FIFO non-empty: pop the head and it wins.
  - Otherwise: no write.
  - alu_valid with alu_rd==0 consumes the slot with no write, and no FIFO pop that cycle.
- Write output: the winner is registered. reg_write/rd/wd assert the cycle after arbitration (latency 1) for exactly one cycle per write; at all other times reg_write=0, rd=0, wd=0.
- Simultaneous push and pop when non-full and non-empty: count unchanged, FIFO order preserved.
- Empty FIFO with a new push: the entry cannot pop in the same cycle (no fall-through). It pops at the earliest in the next cycle.
- Pointers wrap modulo DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the ALU wins.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- alu_stall:
  - Set at the posedge where the counter reaches STARVE_LIMIT with the FIFO still non-empty.
  - While set, the FIFO head wins.
  - Cleared at the posedge of that pop; the counter resets.
  - At most one stall cycle per starvation episode.
- Protocol violation: alu_valid=1 while alu_stall=1. The FIFO still wins and the ALU result is dropped; the bench flags it as an error.
- Packing (LSU FIFO entry width): {rd[4:0], wd[31:0]}, 37 bits.

Optional Feature:
- WB_BYPASS_EN defined:
  - Adds inputs byp_rs1 and byp_rs2 (5 bits each).
  - Adds outputs byp_hit1, byp_hit2 (1 bit) and byp_data (32 bits).
  - byp_hitN = reg_write && rd==byp_rsN && rd!=0, combinational from the registered write outputs.
  - byp_data = wd.
  - Covers the cycle in which the register file has not yet absorbed the write.
- Undefined: these ports do not exist, and core forwarding is responsible for that window.

Test Plan:
- ALU only: alu_valid=1, rd=5, wd=0xDEADBEEF at cycle N -> reg_write=1, rd=5, wd=0xDEADBEEF at N+1 only; alu_rd=0 -> no reg_write.
- LSU only: push rd=3/0x11, rd=4/0x22, rd=0/0x33 back-to-back -> writes (3,0x11) then (4,0x22) on consecutive cycles starting 2 cycles after the first push; x0 entry never written; fifo_count returns to 0.
- Full FIFO: DEPTH=4, ALU busy, push 5 LSU results -> lsu_ready=0 after the 4th; 5th held until a pop; order preserved.
- Starvation: STARVE_LIMIT=8, one LSU entry, ALU valid every cycle -> alu_stall=1 after 8 ALU wins; next write is the LSU entry; alu_stall=0 the following cycle.
- Reset mid-operation: 3 entries queued, rst=1 for 1 cycle -> fifo_count=0, reg_write=0, alu_stall=0; queued entries never written.
- WB_BYPASS_EN: write rd=7/0xCAFE, byp_rs1=7, byp_rs2=0 -> byp_hit1=1, byp_data=0xCAFE, byp_hit2=0 in the reg_write cycle; both hits 0 the next cycle.
